// File: rtl/ramp_gen_p.sv
// Handshaked up/down ramp generator: ramps from mid-scale by K per clock for H clocks, then returns.
// Define RAMP_RETURN_EN to make the return a K-per-clock ramp back to mid-scale instead of a jump.
module ramp_gen_p #(
  parameter int unsigned W  = 8,
  parameter int unsigned HW = 7,
  parameter int unsigned KW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dav_,
  output logic          rfd,
  input  logic          s,
  input  logic [HW-1:0] h,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  out,
  output logic          sat
);

  localparam logic [W-1:0] Mid = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] Max = {W{1'b1}};

  typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;

  state_e        state_q, state_d;
  logic          s_q, s_d;
  logic [HW-1:0] h_q, h_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  out_q, out_d;
  logic          rfd_q, rfd_d;
  logic          sat_q, sat_d;

  // One extra bit of headroom so the step can never wrap past a rail.
  logic [W:0] k_ext, up_sum, dn_diff;
  logic [W:0] gap;

  assign k_ext   = (W+1)'(k_q);
  assign up_sum  = {1'b0, out_q} + k_ext;
  assign dn_diff = {1'b0, out_q} - k_ext;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    h_d     = h_q;
    k_d     = k_q;
    out_d   = out_q;
    rfd_d   = rfd_q;
    sat_d   = sat_q;
    gap     = '0;
    unique case (state_q)
      StIdle: begin
        rfd_d = 1'b1;
        if (!dav_) begin
          s_d     = s;
          h_d     = h;
          k_d     = (k == '0) ? KW'(1) : k;
          rfd_d   = 1'b0;
          sat_d   = 1'b0;
          state_d = (h == '0) ? StDone : StRamp;
        end
      end
      StRamp: begin
        if (!s_q) begin
          out_d = (up_sum >= {1'b0, Max}) ? Max : up_sum[W-1:0];
          if (out_d == Max) sat_d = 1'b1;
        end else begin
          out_d = dn_diff[W] ? '0 : dn_diff[W-1:0];
          if (out_d == '0) sat_d = 1'b1;
        end
        h_d = h_q - HW'(1);
        if (h_q == HW'(1)) state_d = StDone;
      end
      StDone: begin
`ifdef RAMP_RETURN_EN
        // Step back toward mid-scale without overshooting it.
        if (out_q > Mid) begin
          gap   = {1'b0, out_q - Mid};
          out_d = (gap > k_ext) ? out_q - k_ext[W-1:0] : Mid;
        end else if (out_q < Mid) begin
          gap   = {1'b0, Mid - out_q};
          out_d = (gap > k_ext) ? out_q + k_ext[W-1:0] : Mid;
        end
`else
        out_d = Mid;
`endif
        if (dav_ && out_q == Mid) begin
          state_d = StIdle;
          rfd_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= 1'b0;
      h_q     <= '0;
      k_q     <= '0;
      out_q   <= Mid;
      rfd_q   <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      h_q     <= h_d;
      k_q     <= k_d;
      out_q   <= out_d;
      rfd_q   <= rfd_d;
      sat_q   <= sat_d;
    end
  end

  assign out = out_q;
  assign rfd = rfd_q;
  assign sat = sat_q;

endmodule

// File: tb/tb_ramp_gen_p.sv
// Randomized bench for ramp_gen_p; expected trace comes from closed-form ramp arithmetic.
// Honours RAMP_RETURN_EN the same way the design does.
module tb_ramp_gen_p;

  localparam int W   = 8;
  localparam int HW  = 7;
  localparam int KW  = 3;
  localparam int MID = 128;
  localparam int TOP = 255;

  logic          clock = 1'b0;
  logic          reset;
  logic          dav_;
  logic          rfd;
  logic          s;
  logic [HW-1:0] h;
  logic [KW-1:0] k;
  logic [W-1:0]  out;
  logic          sat;

  int total = 0;
  int bad   = 0;
  int exp_sat = 0;

  ramp_gen_p #(.W(W), .HW(HW), .KW(KW)) dut (
    .clock (clock),
    .reset (reset),
    .dav_  (dav_),
    .rfd   (rfd),
    .s     (s),
    .h     (h),
    .k     (k),
    .out   (out),
    .sat   (sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int eo, input int er, input int es);
    check({tag, "_out"}, 32'(out), 32'(eo));
    check({tag, "_rfd"}, 32'(rfd), 32'(er));
    check({tag, "_sat"}, 32'(sat), 32'(es));
  endtask

  // Garbage on the command inputs outside the capture window must be ignored.
  task automatic scramble();
    s = 1'($urandom);
    h = HW'($urandom);
    k = KW'($urandom);
  endtask

  task automatic run_cmd(input int sv, input int hv, input int kv, input int extra_low,
                         input int idle_after);
    int kk, v, d;
    s = 1'(sv); h = HW'(hv); k = KW'(kv);
    dav_ = 1'b0;
    tick();
    check_all("cap", MID, 0, 0);
    exp_sat = 0;
    kk = (kv == 0) ? 1 : kv;
    v = MID;
    for (int i = 1; i <= hv; i++) begin
      scramble();
      tick();
      v = (sv == 0) ? MID + i * kk : MID - i * kk;
      if (v >= TOP) v = TOP;
      if (v <= 0) v = 0;
      if ((sv == 0 && v == TOP) || (sv == 1 && v == 0)) exp_sat = 1;
      check_all("ramp", v, 0, exp_sat);
    end
`ifdef RAMP_RETURN_EN
    while (v != MID) begin
      tick();
      d = (v > MID) ? v - MID : MID - v;
      d = (d > kk) ? d - kk : 0;
      v = (v > MID) ? MID + d : MID - d;
      check_all("ret", v, 0, exp_sat);
    end
`else
    if (hv > 0) begin
      tick();
      check_all("ret", MID, 0, exp_sat);
    end
`endif
    for (int i = 0; i < extra_low; i++) begin
      tick();
      check_all("hold", MID, 0, exp_sat);
    end
    dav_ = 1'b1;
    tick();
    check_all("exit", MID, 1, exp_sat);
    for (int i = 0; i < idle_after; i++) begin
      scramble();
      tick();
      check_all("idle", MID, 1, exp_sat);
    end
  endtask

  initial begin
    reset = 1'b1;
    dav_  = 1'b1;
    s = 1'b0; h = '0; k = '0;
    tick();
    tick();
    reset = 1'b0;
    check_all("rst", MID, 1, 0);
    for (int i = 0; i < 10; i++) begin
      scramble();
      tick();
      check_all("idle0", MID, 1, 0);
    end

    run_cmd(0, 3, 1, 2, 1);
    run_cmd(1, 100, 2, 1, 2);
    run_cmd(0, 0, 5, 3, 1);
    run_cmd(0, 127, 7, 0, 1);
    run_cmd(0, 4, 3, 1, 1);
    run_cmd(1, 5, 0, 0, 0);

    // Reset in the middle of a ramp aborts it.
    s = 1'b0; h = HW'(20); k = KW'(1);
    dav_ = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_all("pre", MID + i, 0, 0);
    end
    reset = 1'b1;
    tick();
    check_all("midrst", MID, 1, 0);
    reset = 1'b0;
    dav_  = 1'b1;
    tick();
    check_all("postrst", MID, 1, 0);
    exp_sat = 0;
    run_cmd(1, 2, 3, 0, 1);

    for (int n = 0; n < 25; n++) begin
      run_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
